// File: rtl/opll_pkg.sv
// Shared types and default timing constants for the OPLL write pacer.
package opll_pkg;

    localparam int OPLL_ADDR_WAIT_DEF = 12;
    localparam int OPLL_DATA_WAIT_DEF = 84;

    // One queued OPLL access: a0 selects address (0) or data (1).
    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } opll_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT
    } pacer_state_t;

endpackage

// File: rtl/opll_wr_fifo.sv
// Generic synchronous FIFO. Pointers carry an extra wrap bit so full and
// empty fall out of a plain pointer compare. A push while full is only
// taken when a pop happens in the same cycle.
module opll_wr_fifo
    import opll_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(opll_entry_t)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap through the extra bit naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/opll_write_pacer.sv
// OPLL write pacer: queues mapper/I/O register writes and replays them to the
// YM2413 core with the address-to-data and data-to-next waits enforced in ce
// ticks. Define OPLL_SHADOW_EN to add a 64x8 readback shadow of data writes.
module opll_write_pacer
    import opll_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_WAIT = OPLL_ADDR_WAIT_DEF,
    parameter int DATA_WAIT = OPLL_DATA_WAIT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       mem_wr,
    input  logic       io_wr,
    input  logic       io_enable,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       opll_we,
    output logic       opll_a0,
    output logic [7:0] opll_d,
    output logic       busy,
`ifdef OPLL_SHADOW_EN
    output logic       overflow,
    input  logic [5:0] shadow_addr,
    output logic [7:0] shadow_dout
`else
    output logic       overflow
`endif
);

    localparam logic [6:0] ADDR_LOAD = 7'(ADDR_WAIT - 1);
    localparam logic [6:0] DATA_LOAD = 7'(DATA_WAIT - 1);

    pacer_state_t state, state_d;
    logic [6:0]   cnt, cnt_d;
    logic         we_d, a0_d;
    logic [7:0]   d_d;
    logic         io_push, push, pop, full, empty;
    opll_entry_t  head, entry_in;

    // Both sources share a0/din; a simultaneous pair collapses to one push.
    assign io_push  = io_wr && io_enable;
    assign push     = mem_wr || io_push;
    assign entry_in = '{a0: a0, data: din};

    opll_wr_fifo #(.DEPTH(DEPTH), .WIDTH($bits(opll_entry_t))) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (entry_in),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    assign busy = !empty || (state != IDLE);

    // Pacer register bank: state, wait counter and the OPLL-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            opll_we <= 1'b0;
            opll_a0 <= 1'b0;
            opll_d  <= 8'h00;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            opll_we <= we_d;
            opll_a0 <= a0_d;
            opll_d  <= d_d;
        end
    end

    // Next-state logic; nothing moves except on ce ticks.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_d    = opll_we;
        a0_d    = opll_a0;
        d_d     = opll_d;
        pop     = 1'b0;
        if (ce) begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        a0_d    = head.a0;
                        d_d     = head.data;
                        we_d    = 1'b1;
                        cnt_d   = head.a0 ? DATA_LOAD : ADDR_LOAD;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    we_d    = 1'b0;
                    cnt_d   = cnt - 7'd1;
                    state_d = (cnt != 7'd1) ? WAIT : IDLE;
                end
                WAIT: begin
                    cnt_d = cnt - 7'd1;
                    if (cnt == 7'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky drop flag: dual-source collision or push into a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                   overflow <= 1'b0;
        else if ((mem_wr && io_push) || (push && full && !pop)) overflow <= 1'b1;
    end

`ifdef OPLL_SHADOW_EN
    logic [5:0] shadow_idx;
    logic [7:0] shadow [64];

    assign shadow_dout = shadow[shadow_addr];

    // Track the last issued register index and record issued data at it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_idx <= '0;
            for (int i = 0; i < 64; i++) shadow[i] <= 8'h00;
        end else if (pop) begin
            if (head.a0) shadow[shadow_idx] <= head.data;
            else         shadow_idx         <= head.data[5:0];
        end
    end
`endif

endmodule

// File: tb/tb_opll_write_pacer.sv
// Self-checking bench for opll_write_pacer (default build, shadow disabled).
module tb_opll_write_pacer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       mem_wr = 1'b0, io_wr = 1'b0, io_enable = 1'b0, a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       opll_we, opll_a0, busy, overflow;
    logic [7:0] opll_d;

    opll_write_pacer dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mem_wr(mem_wr), .io_wr(io_wr),
        .io_enable(io_enable), .a0(a0), .din(din), .opll_we(opll_we),
        .opll_a0(opll_a0), .opll_d(opll_d), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ce: one clk pulse every 3 clks
    int ce_div = 0;
    always @(negedge clk) begin
        ce_div = (ce_div == 2) ? 0 : ce_div + 1;
        ce     = (ce_div == 0);
    end

    int tick = 0;
    always @(posedge clk) if (reset_n && ce) tick++;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string nm, input bit ok, input int act, input int req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, req, req);
    endtask

    // scoreboard of expected {a0,data} issues
    logic [8:0] exp_q[$];
    int         issue_ticks[$];

    logic we_prev = 1'b0, have_last = 1'b0, last_a0 = 1'b0;
    int   width = 0, last_tick = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            we_prev = 0; have_last = 0; width = 0;
        end else begin
            if (opll_we && !we_prev) begin
                width = 1;
                issue_ticks.push_back(tick);
                check("issue_expected", exp_q.size() > 0, exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("issue_data", {opll_a0, opll_d} == e, {opll_a0, opll_d}, e);
                end
                if (have_last) begin
                    int w;
                    w = last_a0 ? 84 : 12;
                    check("issue_gap", (tick - last_tick) >= w, tick - last_tick, w);
                end
                have_last = 1; last_tick = tick; last_a0 = opll_a0;
            end else if (opll_we) begin
                width++;
            end
            if (!opll_we && we_prev) check("we_width", width == 3, width, 3);
            we_prev = opll_we;
        end
    end

    task automatic strobe(input bit m, input bit io, input bit en, input bit a, input logic [7:0] d);
        @(negedge clk);
        mem_wr = m; io_wr = io; io_enable = en; a0 = a; din = d;
        @(negedge clk);
        mem_wr = 0; io_wr = 0;
    endtask

    task automatic drain(input int max);
        int c;
        c = 0;
        while ((busy || exp_q.size() != 0) && c < max) begin
            @(negedge clk); c++;
        end
        check("drain", c < max, c, max);
    endtask

    task automatic wait_we_fall(input int max);
        int c;
        c = 0;
        while (!opll_we && c < max) begin @(negedge clk); c++; end
        while (opll_we && c < max) begin @(negedge clk); c++; end
        check("we_fall", c < max, c, max);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic gap_exact(input string nm, input int n0, input int req);
        check({nm, "_count"}, issue_ticks.size() >= n0 + 2, issue_ticks.size(), n0 + 2);
        if (issue_ticks.size() >= n0 + 2)
            check(nm, issue_ticks[n0+1] - issue_ticks[n0] == req, issue_ticks[n0+1] - issue_ticks[n0], req);
    endtask

    typedef struct {
        bit         m, io, en, a;
        logic [7:0] d;
        bit         exp_busy;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n0, ni;
        vecs[0] = '{1, 0, 0, 0, 8'h21, 1};
        vecs[1] = '{0, 1, 0, 1, 8'h44, 0};   // io gated off
        vecs[2] = '{0, 1, 1, 1, 8'h33, 1};
        vecs[3] = '{1, 0, 1, 1, 8'hC3, 1};
        vecs[4] = '{0, 0, 1, 0, 8'h00, 0};   // no strobe
        vecs[5] = '{1, 0, 0, 0, 8'h3F, 1};

        // reset values
        repeat (2) @(negedge clk);
        check("rst_we", opll_we == 0, opll_we, 0);
        check("rst_a0", opll_a0 == 0, opll_a0, 0);
        check("rst_d", opll_d == 0, opll_d, 0);
        check("rst_busy", busy == 0, busy, 0);
        check("rst_ovf", overflow == 0, overflow, 0);
        @(negedge clk); reset_n = 1;

        // address then data: exactly 12 ticks apart
        n0 = issue_ticks.size();
        exp_q.push_back({1'b0, 8'h10}); strobe(1, 0, 0, 0, 8'h10);
        exp_q.push_back({1'b1, 8'h5A}); strobe(1, 0, 0, 1, 8'h5A);
        drain(2000);
        gap_exact("addr_gap", n0, 12);

        // io data then queued address: exactly 84 ticks apart
        n0 = issue_ticks.size();
        exp_q.push_back({1'b1, 8'h33}); strobe(0, 1, 1, 1, 8'h33);
        exp_q.push_back({1'b0, 8'h01}); strobe(1, 0, 0, 0, 8'h01);
        drain(2000);
        gap_exact("data_gap", n0, 84);

        // table of single writes
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].m || (vecs[i].io && vecs[i].en)) exp_q.push_back({vecs[i].a, vecs[i].d});
            strobe(vecs[i].m, vecs[i].io, vecs[i].en, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d_busy", i), busy == vecs[i].exp_busy, busy, vecs[i].exp_busy);
            drain(2000);
            check($sformatf("vec%0d_ovf", i), overflow == 0, overflow, 0);
        end

        // burst of 9 during WAIT: 8 kept, 9th dropped
        exp_q.push_back({1'b1, 8'h00}); strobe(1, 0, 0, 1, 8'h00);
        wait_we_fall(200);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            mem_wr = 1; a0 = i[0]; din = 8'h80 + 8'(i);
            if (i < 8) exp_q.push_back({i[0], 8'h80 + 8'(i)});
        end
        @(negedge clk); mem_wr = 0;
        check("burst_ovf", overflow == 1, overflow, 1);
        drain(6000);

        // simultaneous mem + io: one entry, overflow set
        do_reset();
        @(negedge clk);
        check("post_rst_ovf", overflow == 0, overflow, 0);
        ni = issue_ticks.size();
        exp_q.push_back({1'b1, 8'hAA}); strobe(1, 1, 1, 1, 8'hAA);
        check("dual_ovf", overflow == 1, overflow, 1);
        drain(2000);
        check("dual_issues", issue_ticks.size() - ni == 1, issue_ticks.size() - ni, 1);

        // reset mid-WAIT with 3 queued
        do_reset();
        exp_q.push_back({1'b1, 8'h5C}); strobe(1, 0, 0, 1, 8'h5C);
        wait_we_fall(200);
        for (int i = 0; i < 3; i++) strobe(1, 0, 0, 0, 8'h11 + 8'(i));
        @(negedge clk);
        check("pre_rst_busy", busy == 1, busy, 1);
        #1 reset_n = 0;
        #1;
        check("mid_rst_we", opll_we == 0, opll_we, 0);
        check("mid_rst_a0", opll_a0 == 0, opll_a0, 0);
        check("mid_rst_d", opll_d == 0, opll_d, 0);
        check("mid_rst_busy", busy == 0, busy, 0);
        check("mid_rst_ovf", overflow == 0, overflow, 0);
        exp_q.delete();
        @(negedge clk); reset_n = 1;
        ni = issue_ticks.size();
        repeat (400) @(negedge clk);
        check("post_rst_quiet", issue_ticks.size() == ni, issue_ticks.size() - ni, 0);
        check("post_rst_busy", busy == 0, busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/opll_write_pacer.md
Name: opll_write_pacer

Overview:
- Sits directly downstream of the FM-PAC cartridge mapper.
- Collects OPLL register writes from two sources: memory-mapped strobes at 0x7FF4/0x7FF5, and I/O writes to ports 0x7C/0x7D when the mapper's opll_io_enable is set.
- Buffers the writes in a small FIFO.
- Replays them to the YM2413 core at the chip's mandated pace (address-to-data and data-to-next-access waits), so CPU bursts never violate OPLL timing.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2).
- ADDR_WAIT, 12, ce ticks after an address write before the next access.
- DATA_WAIT, 84, ce ticks after a data write before the next access.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  OPLL clock enable, one clk pulse per 3.58 MHz period
- mem_wr  in  1  one-cycle write strobe from mapper (opll_wr)
- io_wr  in  1  one-cycle I/O write strobe, ports 0x7C/0x7D
- io_enable  in  1  mapper's opll_io_enable; gates io_wr
- a0  in  1  cpu_addr[0] at strobe time: 0 = address, 1 = data
- din  in  8  write data at strobe time
- opll_we  out  1  write strobe to OPLL core
- opll_a0  out  1  register/data select to OPLL core
- opll_d  out  8  data to OPLL core
- busy  out  1  FIFO non-empty or pacer not IDLE
- overflow  out  1  sticky: a write was dropped

Behaviour:
- Push request: push = mem_wr | (io_wr & io_enable). Entry = {a0, din}, 9 bits.
- Simultaneous mem_wr and gated io_wr in one clk: the mem entry is pushed, the io entry is dropped, overflow is set.
- Full FIFO:
  - A push without a same-cycle pop is dropped and sets overflow; FIFO contents are unchanged.
  - A push with a same-cycle pop is accepted.
- Empty FIFO: a same-cycle push and issue is not bypassed; the entry is issued no earlier than the next ce tick.
- Pointers are log2(DEPTH) bits with an extra wrap bit. Full/empty are decided by comparing pointers; both pointers wrap naturally.
- Pacer FSM, advancing only on clk edges where ce=1:
  - IDLE: if FIFO non-empty, pop; register opll_a0/opll_d; opll_we<=1; load cnt<=(a0 ? DATA_WAIT : ADDR_WAIT)-1; go to HOLD.
  - HOLD: opll_we<=0; cnt<=cnt-1; go to WAIT if cnt-1 != 0, else IDLE.
  - WAIT: cnt<=cnt-1; go to IDLE when cnt reaches 0.
- Net timing:
  - opll_we is high for exactly one ce period.
  - If the issue tick is T, the next issue occurs no earlier than ce tick T+ADDR_WAIT or T+DATA_WAIT.
  - Pushes are captured on any clk, independent of ce.
- cnt is 7 bits; both wait parameters must be ≤127 and ≥2.
- opll_a0 and opll_d hold their last value after the strobe.
- Reset values (async, any state, including mid-HOLD/WAIT): FIFO empty, state IDLE, cnt=0, opll_we=0, opll_a0=0, opll_d=0x00, busy=0, overflow=0. An in-flight write is abandoned, not completed.
- overflow clears only on reset.

Optional Feature:
- Macro: OPLL_SHADOW_EN.
- With the macro defined:
  - Adds a 64x8 shadow register file and ports shadow_addr (in, 6) and shadow_dout (out, 8, combinational read).
  - The last issued address write (low 6 bits) is latched internally; each issued data write stores opll_d at that index.
  - The shadow is cleared to 0x00 on reset. It is used for save-state and debug readback.
- Without the macro: no shadow storage and no shadow ports.

Decomposition:
- Package opll_pkg:
  - typedef opll_entry_t {a0, data[7:0]};
  - enum pacer_state_t {IDLE, HOLD, WAIT};
  - constants OPLL_ADDR_WAIT_DEF=12 and OPLL_DATA_WAIT_DEF=84.
- One sub-module, opll_wr_fifo: a generic synchronous FIFO with push/pop/full/empty that instantiates the DEPTH storage. The pacer FSM stays in the top block.

Test Plan:
- Single mem_wr a0=0 din=0x10, then a0=1 din=0x5A → two opll_we pulses of one ce period each; second issue exactly 12 ce ticks after the first; opll_d=0x10, then 0x5A.
- io_wr with io_enable=0 → no push, busy stays 0. With io_enable=1, a0=1 din=0x33 → issued; next issue held ≥84 ce ticks.
- Burst of 9 mem_wr back-to-back while pacer is in WAIT (DEPTH=8) → 8 entries issued in order, 9th dropped, overflow=1.
- Same-clk mem_wr (din=0xAA) and io_wr (din=0xBB) → only 0xAA issued; overflow=1.
- Assert reset_n=0 mid-WAIT with 3 entries queued → outputs go to reset values immediately; after release, no further strobes.
- OPLL_SHADOW_EN: write addr 0x30, data 0x7F → shadow_addr=0x30 reads 0x7F; others read 0x00.
